// File: rtl/uart_memdump_ctrl.sv
// uart_memdump_ctrl: walks an inclusive address range of a synchronous-read
// memory and streams each word out on TX as 8N1 frames, either as raw bytes
// or as uppercase ASCII hex followed by CR LF.
module uart_memdump_ctrl #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int CLKS_PER_BIT = 434,
   parameter int RD_LAT       = 1,
   parameter int MSB_FIRST    = 1
) (
   input  logic              CLK,
   input  logic              nrst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              hex_mode,
   input  logic [DATA_W-1:0] con_data,
   output logic [ADDR_W-1:0] con_addr,
   output logic              TX,
   output logic              busy,
   output logic              done
);

   localparam int NB   = DATA_W / 8;
   localparam int NN   = DATA_W / 4;
   localparam int CI_W = $clog2(NN + 3);
   localparam int BC_W = $clog2(CLKS_PER_BIT + 1);

   localparam logic [CI_W-1:0] RAW_LAST  = CI_W'(NB - 1);
   localparam logic [CI_W-1:0] HEX_LAST  = CI_W'(NN + 1);
   localparam logic [BC_W-1:0] BAUD_LAST = BC_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_NEXT, S_FINISH} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] end_q;
   logic              hex_q;
   logic [DATA_W-1:0] word_q;
   logic [8:0]        tx_sh;      // {stop, data[7:0]}; shifted out LSB first
   logic [3:0]        bit_idx;    // 0 = start bit, 9 = stop bit
   logic [BC_W-1:0]   baud_cnt;
   logic [CI_W-1:0]   char_idx;
   logic [RD_LAT:0]   vld_pipe;   // tracks read latency since the last address change

   logic              accept, capture, bit_end, frame_end, word_end, last_word, launch;
   logic [CI_W-1:0]   char_last;
   logic [7:0]        char_nxt;

   // Character idx of word w: a raw byte, or a hex digit / CR / LF.
   function automatic logic [7:0] char_of(input logic [DATA_W-1:0] w,
                                          input logic [CI_W-1:0]   idx,
                                          input logic              hx);
      logic [DATA_W-1:0] t;
      logic [3:0]        nib;
      int                amt;
      char_of = 8'h0A;
      if (!hx) begin
         amt     = (MSB_FIRST != 0) ? 8 * (NB - 1 - int'(idx)) : 8 * int'(idx);
         t       = w >> amt;
         char_of = t[7:0];
      end else if (int'(idx) < NN) begin
         t       = w >> (4 * (NN - 1 - int'(idx)));
         nib     = t[3:0];
         char_of = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end else if (int'(idx) == NN) begin
         char_of = 8'h0D;
      end
   endfunction

   // State register.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and datapath strobes.
   always_comb begin
      state_nxt = state;
      accept    = (state == S_IDLE) && start;
      capture   = (state == S_FETCH) && vld_pipe[RD_LAT];
      bit_end   = (state == S_SEND) && (baud_cnt == BAUD_LAST);
      frame_end = bit_end && (bit_idx == 4'd9);
      char_last = hex_q ? HEX_LAST : RAW_LAST;
      word_end  = frame_end && (char_idx == char_last);
      last_word = (con_addr == end_q);
      // The address moves as the last stop bit ends, so the NEXT cycle already
      // counts toward read latency and the inter-word gap is RD_LAT+1 cycles.
      launch    = accept || (word_end && !last_word);
      char_nxt  = char_of(capture ? con_data : word_q,
                          capture ? '0 : char_idx + 1'b1, hex_q);
      case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH:  if (capture) state_nxt = S_SEND;
         S_SEND:   if (word_end) state_nxt = last_word ? S_FINISH : S_NEXT;
         S_NEXT:   state_nxt = S_FETCH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Address walk, handshake, word capture and 8N1 serialiser.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         con_addr <= '0;
         TX       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         end_q    <= '0;
         hex_q    <= 1'b0;
         word_q   <= '0;
         tx_sh    <= '1;
         bit_idx  <= '0;
         baud_cnt <= '0;
         char_idx <= '0;
         vld_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[RD_LAT-1:0], launch};
         done     <= (state == S_FINISH);
         if (state == S_FINISH) busy <= 1'b0;

         if (accept) begin
            end_q    <= end_addr;
            hex_q    <= hex_mode;
            con_addr <= start_addr;
            busy     <= 1'b1;
         end

         if (word_end && !last_word) con_addr <= con_addr + 1'b1;

         if (capture) begin
            word_q   <= con_data;
            tx_sh    <= {1'b1, char_nxt};
            TX       <= 1'b0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            char_idx <= '0;
         end else if (state == S_SEND) begin
            if (!bit_end) begin
               baud_cnt <= baud_cnt + 1'b1;
            end else begin
               baud_cnt <= '0;
               if (bit_idx != 4'd9) begin
                  TX      <= tx_sh[0];
                  tx_sh   <= {1'b1, tx_sh[8:1]};
                  bit_idx <= bit_idx + 1'b1;
               end else if (!word_end) begin
                  // next character of the same word starts with no gap
                  tx_sh    <= {1'b1, char_nxt};
                  TX       <= 1'b0;
                  bit_idx  <= '0;
                  char_idx <= char_idx + 1'b1;
               end else begin
                  TX <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_memdump_ctrl.sv
// tb_uart_memdump_ctrl: directed bench for uart_memdump_ctrl with two
// instances (MSB-first and LSB-first), a registered memory model and an
// 8N1 receiver per instance.
module tb_uart_memdump_ctrl;

   logic              CLK = 1'b0;
   logic              nrst;
   logic              start;
   logic [9:0]        start_addr, end_addr;
   logic              hex_mode;
   logic [1:0][31:0]  cd;
   logic [1:0][9:0]   ca;
   logic [1:0]        tx, bsy, dn;

   logic [31:0] mem [1024];

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          n_done = 0;

   logic [7:0]  rx_b  [2][256];
   int          rx_t  [2][256];
   logic [9:0]  rx_a  [2][256];
   logic [7:0]  rx_n  [2];
   int          rx_ferr [2];

   always #10 CLK = ~CLK;

   uart_memdump_ctrl #(.ADDR_W(10), .DATA_W(32), .CLKS_PER_BIT(4), .RD_LAT(1), .MSB_FIRST(1)) u_dut0 (
      .CLK(CLK), .nrst(nrst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
      .hex_mode(hex_mode), .con_data(cd[0]), .con_addr(ca[0]), .TX(tx[0]), .busy(bsy[0]), .done(dn[0]));

   uart_memdump_ctrl #(.ADDR_W(10), .DATA_W(32), .CLKS_PER_BIT(4), .RD_LAT(1), .MSB_FIRST(0)) u_dut1 (
      .CLK(CLK), .nrst(nrst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
      .hex_mode(hex_mode), .con_data(cd[1]), .con_addr(ca[1]), .TX(tx[1]), .busy(bsy[1]), .done(dn[1]));

   // Memory with one cycle of read latency.
   always @(posedge CLK) begin
      cd[0] <= mem[ca[0]];
      cd[1] <= mem[ca[1]];
      cyc   <= cyc + 1;
   end

   always @(negedge CLK) if (dn[0]) n_done <= n_done + 1;

   // 8N1 receivers, sampling each bit mid-way (4 cycles per bit).
   for (genvar g = 0; g < 2; g++) begin : g_mon
      int   cnt  = 0;
      bit   busy_r = 1'b0;
      logic [7:0] sh = 8'h00;
      initial begin rx_n[g] = 8'd0; rx_ferr[g] = 0; end
      always @(negedge CLK) begin
         if (!nrst) begin
            busy_r <= 1'b0;
         end else if (!busy_r) begin
            if (!tx[g]) begin
               busy_r <= 1'b1;
               cnt    <= 1;
               rx_t[g][rx_n[g]] <= cyc;
               rx_a[g][rx_n[g]] <= ca[g];
            end
         end else begin
            cnt <= cnt + 1;
            if (cnt % 4 == 2 && cnt >= 6 && cnt <= 34) sh <= {tx[g], sh[7:1]};
            if (cnt == 38 && !tx[g]) rx_ferr[g] <= rx_ferr[g] + 1;
            if (cnt == 39) begin
               busy_r   <= 1'b0;
               rx_b[g][rx_n[g]] <= sh;
               rx_n[g]  <= rx_n[g] + 8'd1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic start_dump(input logic [9:0] sa, input logic [9:0] ea, input logic hx);
      @(negedge CLK);
      start_addr = sa; end_addr = ea; hex_mode = hx; start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (dn[0] !== 1'b1 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      chk(tag, 32'(k < budget), 32'd1);
      repeat (3) @(negedge CLK);
   endtask

   logic [7:0]  b0, b1;
   int          d0;
   logic [7:0]  hx_exp [10];
   logic [7:0]  raw_exp [4];
   int          wr_addr [4];
   logic [31:0] wv;

   initial begin
      hx_exp  = '{8'h41, 8'h44, 8'h45, 8'h31, 8'h42, 8'h30, 8'h35, 8'h36, 8'h0D, 8'h0A};
      raw_exp = '{8'hAD, 8'hE1, 8'hB0, 8'h56};
      wr_addr = '{1022, 1023, 0, 1};
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
      mem[5] = 32'hADE1B056;
      nrst = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0; hex_mode = 1'b0;

      // reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_tx",   32'(tx[0]), 32'd1);
      chk("rst_busy", 32'(bsy[0]), 32'd0);
      chk("rst_done", 32'(dn[0]), 32'd0);
      chk("rst_addr", 32'(ca[0]), 32'd0);
      @(negedge CLK) nrst = 1'b1;

      // raw single word, both byte orders
      b0 = rx_n[0]; b1 = rx_n[1]; d0 = n_done;
      start_dump(10'd5, 10'd5, 1'b0);
      chk("raw_busy_set", 32'(bsy[0]), 32'd1);
      chk("raw_tx_n0", 32'(tx[0]), 32'd1);
      @(posedge CLK); #1 chk("raw_tx_n1", 32'(tx[0]), 32'd1);
      @(posedge CLK); #1 chk("raw_start_bit", 32'(tx[0]), 32'd0);
      wait_done("raw_timeout", 400);
      chk("raw_nbytes", 32'(rx_n[0] - b0), 32'd4);
      chk("lsb_nbytes", 32'(rx_n[1] - b1), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("raw_msb_byte", 32'(rx_b[0][b0 + 8'(i)]), 32'(raw_exp[i]));
         chk("raw_lsb_byte", 32'(rx_b[1][b1 + 8'(i)]), 32'(raw_exp[3 - i]));
      end
      chk("raw_frame_gap", 32'(rx_t[0][b0 + 8'd1] - rx_t[0][b0]), 32'd40);
      chk("raw_frame3",    32'(rx_t[0][b0 + 8'd3] - rx_t[0][b0]), 32'd120);
      chk("raw_done_cnt", 32'(n_done - d0), 32'd1);
      chk("raw_busy_clr", 32'(bsy[0]), 32'd0);
      chk("raw_addr_hold", 32'(ca[0]), 32'd5);

      // hex mode
      b0 = rx_n[0];
      start_dump(10'd5, 10'd5, 1'b1);
      wait_done("hex_timeout", 600);
      chk("hex_nbytes", 32'(rx_n[0] - b0), 32'd10);
      for (int i = 0; i < 10; i++)
         chk("hex_char", 32'(rx_b[0][b0 + 8'(i)]), 32'(hx_exp[i]));

      // range through the wrap, with an ignored start mid-dump
      b0 = rx_n[0]; d0 = n_done;
      start_dump(10'd1022, 10'd1, 1'b0);
      repeat (100) @(posedge CLK);
      start_dump(10'd7, 10'd7, 1'b1);
      wait_done("wrap_timeout", 1200);
      chk("wrap_nbytes", 32'(rx_n[0] - b0), 32'd16);
      for (int w = 0; w < 4; w++) begin
         wv = 32'(wr_addr[w]);
         chk("wrap_addr", 32'(rx_a[0][b0 + 8'(4 * w)]), wv);
         for (int k = 0; k < 4; k++)
            chk("wrap_byte", 32'(rx_b[0][b0 + 8'(4 * w + k)]), 32'(wv[8 * (3 - k) +: 8]));
      end
      chk("wrap_gap01", 32'(rx_t[0][b0 + 8'd4] - rx_t[0][b0 + 8'd3]), 32'd42);
      chk("wrap_gap23", 32'(rx_t[0][b0 + 8'd12] - rx_t[0][b0 + 8'd11]), 32'd42);
      chk("wrap_done_cnt", 32'(n_done - d0), 32'd1);
      chk("wrap_addr_end", 32'(ca[0]), 32'd1);

      // asynchronous reset in the middle of data bit 1 (0 for 0xAD)
      start_dump(10'd5, 10'd5, 1'b0);
      repeat (10) @(posedge CLK);
      #5;
      chk("pre_rst_tx", 32'(tx[0]), 32'd0);
      nrst = 1'b0;
      #1;
      chk("arst_tx",   32'(tx[0]), 32'd1);
      chk("arst_busy", 32'(bsy[0]), 32'd0);
      chk("arst_addr", 32'(ca[0]), 32'd0);
      #40;
      @(negedge CLK) nrst = 1'b1;

      // clean dump after reset
      b0 = rx_n[0]; d0 = n_done;
      start_dump(10'd1, 10'd1, 1'b0);
      wait_done("post_rst_timeout", 400);
      chk("post_rst_nbytes", 32'(rx_n[0] - b0), 32'd4);
      chk("post_rst_last", 32'(rx_b[0][b0 + 8'd3]), 32'h01);
      chk("post_rst_done", 32'(n_done - d0), 32'd1);
      chk("frame_err0", 32'(rx_ferr[0]), 32'd0);
      chk("frame_err1", 32'(rx_ferr[1]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_memdump_ctrl.md
Name: uart_memdump_ctrl

Overview:
Parametrised UART memory-dump engine that walks an inclusive address range of a synchronous-read memory and serialises each word on TX as 8N1 frames. It is the successor to the fixed 10-bit/32-bit dumper. New capabilities:
- configurable address and data width, baud divisor and read latency
- software start/busy/done handshake with programmable start/end addresses
- raw-binary or ASCII-hex output mode

It sits beside the data memory's debug/console read port and drives the board UART TX pin.

Parameters:
ADDR_W, 10, width of con_addr and range ports
DATA_W, 32, memory word width; must be a multiple of 8
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200)
RD_LAT, 1, cycles from con_addr change to valid con_data (>=1)
MSB_FIRST, 1, raw mode byte order: 1 = most-significant byte first, 0 = least-significant first

Ports:
CLK  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  begin dump; sampled only in IDLE
start_addr  in  ADDR_W  first word address; latched when start is accepted
end_addr  in  ADDR_W  last word address (inclusive); latched when start is accepted
hex_mode  in  1  0 = raw bytes, 1 = ASCII hex plus CR LF per word; latched when start is accepted
con_data  in  DATA_W  memory read data
con_addr  out  ADDR_W  memory read address (registered)
TX  out  1  UART serial output, idle high
busy  out  1  high from accepted start until dump completes
done  out  1  one-cycle pulse when the last stop bit finishes

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (nrst). All state is cleared immediately when nrst=0, independent of CLK.
- Reset values: TX=1, con_addr=0, busy=0, done=0, FSM=IDLE. A reset mid-frame truncates the frame; TX returns high at once.
- FSM states: IDLE -> FETCH -> SEND -> (NEXT -> FETCH | FINISH -> IDLE).
- IDLE:
  - start=1 at edge N latches the range and mode registers.
  - At the same edge: con_addr<=start_addr, busy<=1, state<=FETCH.
- FETCH:
  - Waits RD_LAT cycles.
  - At edge N+RD_LAT+1: captures con_data into the word register, loads the first character, and drives TX=0 (start bit). State<=SEND.
- Frame format:
  - start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles, so one frame = 10*CLKS_PER_BIT cycles.
  - Consecutive characters of the same word are back-to-back, with no idle gap.
- Raw mode (hex_mode=0): DATA_W/8 characters per word, ordered according to MSB_FIRST.
- Hex mode (hex_mode=1):
  - DATA_W/4 characters, most-significant nibble first.
  - Nibbles 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase).
  - The word is followed by 0x0D then 0x0A.
- NEXT: entered after a word's final stop bit when con_addr != latched end.
  - con_addr<=con_addr+1, modulo 2^ADDR_W (wraps from all-ones to 0).
  - Returns to FETCH, so TX idles high for exactly RD_LAT+1 cycles between words.
- FINISH: entered after the final stop bit when con_addr == latched end.
  - Next edge: busy<=0, done<=1 for one cycle, state<=IDLE.
  - con_addr holds the last address read.
- Range rules:
  - start_addr==end_addr dumps one word.
  - end_addr<start_addr dumps through the wrap, i.e. (end-start) mod 2^ADDR_W + 1 words.
- start while busy is ignored; input changes after latching have no effect on the dump in progress.
- start held high continuously re-triggers a new dump one cycle after done.
- con_data is sampled only at the capture edge; changes at other times have no effect.
- Bit counter and baud counter: no cumulative drift. Frame k of a word begins exactly 10*CLKS_PER_BIT*k cycles after the word's first start bit.

Test Plan:
- Common bench setup: CLKS_PER_BIT=4, RD_LAT=1, 20 ns clock, memory model returns mem[con_addr] one cycle later.
- Raw single word: mem[5]=0xADE1B056, start/end=5, hex_mode=0.
  -> TX bytes AD E1 B0 56, 160 cycles of frames, first start bit 2 cycles after start.
  -> done pulses once; busy=0 after.
- Raw, MSB_FIRST=0, same stimulus -> bytes 56 B0 E1 AD.
- Hex mode, mem[5]=0xADE1B056 -> 10 frames 0x41 0x44 0x45 0x31 0x42 0x30 0x35 0x36 0x0D 0x0A.
- Range and wrap: start=1022, end=1, mem[a]=a.
  -> con_addr sequence 1022, 1023, 0, 1; 16 raw bytes.
  -> exactly 2 idle-high cycles between words; a single done pulse.
- Handshake and reset:
  - start pulsed again mid-dump -> ignored, byte count unchanged.
  - nrst=0 asserted mid-data-bit -> TX=1, busy=0, con_addr=0 immediately, without waiting for a clock edge.
  - After release, a new start runs a clean dump.
